// File: rtl/cpu_trace_buffer_if.sv
// Trace capture bus: retired-instruction feed in, oldest-first readout stream out.
interface cpu_trace_buffer_if #(
  parameter int PC_W   = 4,
  parameter int INST_W = 8,
  parameter int DATA_W = 4
);
  logic                           trace_valid;
  logic [PC_W-1:0]                trace_pc;
  logic [INST_W-1:0]              trace_inst;
  logic [DATA_W-1:0]              trace_result;
  logic                           rd_valid;
  logic                           rd_ready;
  logic [PC_W+INST_W+DATA_W-1:0]  rd_data;
  logic                           rd_last;

  // Core feed and trace consumer side
  modport master (
    output trace_valid, trace_pc, trace_inst, trace_result, rd_ready,
    input  rd_valid, rd_data, rd_last
  );

  // Trace buffer side
  modport slave (
    input  trace_valid, trace_pc, trace_inst, trace_result, rd_ready,
    output rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/cpu_trace_buffer.sv
// Circular execution-trace buffer: captures {pc, inst, result} while armed,
// stops post_count entries after a trigger, then streams the window oldest-first.
module cpu_trace_buffer #(
  parameter int PC_W   = 4,
  parameter int INST_W = 8,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  cpu_trace_buffer_if.slave  bus,
  input  logic               arm,
  input  logic               trig_pc_en,
  input  logic [PC_W-1:0]    trig_pc,
  input  logic               force_trig,
  input  logic [PTR_W-1:0]   post_count,
  output logic [1:0]         state,
  output logic [PTR_W:0]     fill,
  output logic               wrapped
);
  localparam int ENT_W = PC_W + INST_W + DATA_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_POST  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(1'b0);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1'b1);
  localparam logic [PTR_W:0]   FILL_ZERO = (PTR_W+1)'(1'b0);
  localparam logic [PTR_W:0]   FILL_ONE  = (PTR_W+1)'(1'b1);
  localparam logic [PTR_W:0]   FILL_TWO  = (PTR_W+1)'(2'd2);
  localparam logic [PTR_W:0]   FILL_FULL = (PTR_W+1)'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    fill_q, fill_d;
  logic              wrapped_q, wrapped_d;
  logic [PTR_W-1:0]  remaining_q, remaining_d;
  logic [PTR_W:0]    rd_cnt_q, rd_cnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic [ENT_W-1:0]  rd_data_q, rd_data_d;
  logic [ENT_W-1:0]  mem_q [DEPTH];

  logic              trig_s;
  logic              wr_en_s;
  logic [ENT_W-1:0]  entry_s;
  logic [PTR_W-1:0]  rd_start_s;
  logic [PTR_W-1:0]  rd_next_s;

  assign trig_s     = force_trig | (bus.trace_valid & trig_pc_en & (bus.trace_pc == trig_pc));
  assign wr_en_s    = ~arm & bus.trace_valid & ((state_q == ST_ARMED) | (state_q == ST_POST));
  assign entry_s    = {bus.trace_pc, bus.trace_inst, bus.trace_result};
  // Once wrapped, the oldest surviving entry sits where the next write would land
  assign rd_start_s = wrapped_q ? wr_ptr_q : PTR_ZERO;
  assign rd_next_s  = rd_ptr_q + PTR_ONE;

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= PTR_ZERO;
      rd_ptr_q    <= PTR_ZERO;
      fill_q      <= FILL_ZERO;
      wrapped_q   <= 1'b0;
      remaining_q <= PTR_ZERO;
      rd_cnt_q    <= FILL_ZERO;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= {ENT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      wrapped_q   <= wrapped_d;
      remaining_q <= remaining_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Trace storage; contents need no reset since fill/wrapped qualify them
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= entry_s;
    end
  end

  // Next-state logic; arm restarts capture from any state
  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = ST_ARMED;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_ARMED: begin
          if (trig_s) begin
            state_d = (post_count == PTR_ZERO) ? ST_DONE : ST_POST;
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_POST: begin
          if (bus.trace_valid && (remaining_q == PTR_ONE)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_POST;
          end
        end
        ST_DONE: begin
          if (!rd_valid_q) begin
            state_d = (fill_q == FILL_ZERO) ? ST_IDLE : ST_DONE;
          end else if (bus.rd_ready && rd_last_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Capture pointers, post-trigger countdown and readout stream
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fill_d      = fill_q;
    wrapped_d   = wrapped_q;
    remaining_d = remaining_q;
    rd_cnt_d    = rd_cnt_q;
    rd_valid_d  = rd_valid_q;
    rd_last_d   = rd_last_q;
    rd_data_d   = rd_data_q;
    if (arm) begin
      wr_ptr_d    = PTR_ZERO;
      rd_ptr_d    = PTR_ZERO;
      fill_d      = FILL_ZERO;
      wrapped_d   = 1'b0;
      remaining_d = PTR_ZERO;
      rd_cnt_d    = FILL_ZERO;
      rd_valid_d  = 1'b0;
      rd_last_d   = 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_d  = wr_ptr_q + PTR_ONE;
        fill_d    = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_ONE;
        wrapped_d = wrapped_q | (fill_q == FILL_FULL);
      end else begin
        wr_ptr_d  = wr_ptr_q;
      end
      case (state_q)
        ST_ARMED: begin
          if (trig_s) begin
            remaining_d = post_count;
          end else begin
            remaining_d = remaining_q;
          end
        end
        ST_POST: begin
          if (bus.trace_valid) begin
            remaining_d = remaining_q - PTR_ONE;
          end else begin
            remaining_d = remaining_q;
          end
        end
        ST_DONE: begin
          if (!rd_valid_q) begin
            if (fill_q != FILL_ZERO) begin
              rd_valid_d = 1'b1;
              rd_ptr_d   = rd_start_s;
              rd_data_d  = mem_q[rd_start_s];
              rd_cnt_d   = fill_q;
              rd_last_d  = (fill_q == FILL_ONE);
            end else begin
              rd_valid_d = 1'b0;
            end
          end else if (bus.rd_ready) begin
            if (rd_last_q) begin
              rd_valid_d = 1'b0;
              rd_last_d  = 1'b0;
            end else begin
              rd_ptr_d   = rd_next_s;
              rd_data_d  = mem_q[rd_next_s];
              rd_cnt_d   = rd_cnt_q - FILL_ONE;
              rd_last_d  = (rd_cnt_q == FILL_TWO);
            end
          end else begin
            rd_valid_d = rd_valid_q;
          end
        end
        default: remaining_d = remaining_q;
      endcase
    end
  end

  assign state        = state_q;
  assign fill         = fill_q;
  assign wrapped      = wrapped_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_last  = rd_last_q;
  assign bus.rd_data  = rd_data_q;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Randomized and directed bench for cpu_trace_buffer against a queue-based capture model.
module tb_cpu_trace_buffer;
  localparam int PC_W = 4, INST_W = 8, DATA_W = 4, DEPTH = 8, PTR_W = 3;

  logic clk = 1'b0;
  logic reset;
  logic arm, trig_pc_en, force_trig;
  logic [PC_W-1:0]  trig_pc;
  logic [PTR_W-1:0] post_count;
  logic [1:0]       state;
  logic [PTR_W:0]   fill;
  logic             wrapped;

  cpu_trace_buffer_if #(.PC_W(PC_W), .INST_W(INST_W), .DATA_W(DATA_W)) bus ();

  cpu_trace_buffer #(.PC_W(PC_W), .INST_W(INST_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus), .arm(arm), .trig_pc_en(trig_pc_en),
    .trig_pc(trig_pc), .force_trig(force_trig), .post_count(post_count),
    .state(state), .fill(fill), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  // Model: every entry written since arm, plus the pending readout window
  int m_state, m_rem;
  bit m_rv;
  logic [15:0] hist[$];
  logic [15:0] rdq[$];
  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_rem = 0; m_rv = 1'b0;
    hist.delete(); rdq.delete();
  endtask

  task automatic model_step();
    bit trig;
    int n;
    if (arm) begin
      model_reset();
      m_state = 1;
    end else begin
      case (m_state)
        1: begin
          trig = force_trig || (bus.trace_valid && trig_pc_en && bus.trace_pc == trig_pc);
          if (bus.trace_valid) hist.push_back({bus.trace_pc, bus.trace_inst, bus.trace_result});
          if (trig) begin
            if (post_count == 3'd0) m_state = 3;
            else begin m_rem = int'(post_count); m_state = 2; end
          end
        end
        2: if (bus.trace_valid) begin
          hist.push_back({bus.trace_pc, bus.trace_inst, bus.trace_result});
          m_rem--;
          if (m_rem == 0) m_state = 3;
        end
        3: begin
          if (!m_rv) begin
            n = hist.size();
            if (n == 0) m_state = 0;
            else begin
              for (int i = (n > DEPTH) ? n - DEPTH : 0; i < n; i++) rdq.push_back(hist[i]);
              m_rv = 1'b1;
            end
          end else if (bus.rd_ready) begin
            void'(rdq.pop_front());
            if (rdq.size() == 0) begin m_rv = 1'b0; m_state = 0; end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    int n;
    n = hist.size();
    chk("state", 32'(state), 32'(m_state));
    chk("fill", 32'(fill), 32'((n > DEPTH) ? DEPTH : n));
    chk("wrapped", 32'(wrapped), 32'(n > DEPTH));
    chk("rd_valid", 32'(bus.rd_valid), 32'(m_rv));
    chk("rd_last", 32'(bus.rd_last), 32'(m_rv && rdq.size() == 1));
    if (m_rv) chk("rd_data", 32'(bus.rd_data), 32'(rdq[0]));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    arm = 1'b0; force_trig = 1'b0; bus.trace_valid = 1'b0;
  endtask

  task automatic push(input logic [3:0] p);
    bus.trace_valid  = 1'b1;
    bus.trace_pc     = p;
    bus.trace_inst   = 8'h10 + {4'h0, p};
    bus.trace_result = p;
    cycle();
  endtask

  // stall_len: ready held low this many cycles before each accept
  task automatic drain(input int stall_len);
    int k;
    k = 0;
    while (m_state != 0 && k < 200) begin
      bus.rd_ready = ((k % (stall_len + 1)) == stall_len);
      cycle();
      k++;
    end
    chk("drain_timeout", 32'(m_state == 0), 32'd1);
    bus.rd_ready = 1'b0;
  endtask

  task automatic basic_capture();
    arm = 1'b1; cycle();
    for (int p = 0; p < 5; p++) push(4'(p));
    force_trig = 1'b1; post_count = 3'd0; cycle();
    chk("basic_done", 32'(state), 32'd3);
    chk("basic_fill", 32'(fill), 32'd5);
    drain(0);
    chk("basic_idle", 32'(state), 32'd0);
  endtask

  initial begin
    reset = 1'b0; arm = 1'b0; trig_pc_en = 1'b0; trig_pc = 4'h0; force_trig = 1'b0;
    post_count = 3'd0; bus.trace_valid = 1'b0; bus.trace_pc = 4'h0; bus.trace_inst = 8'h00;
    bus.trace_result = 4'h0; bus.rd_ready = 1'b0;
    model_reset();
    #12;
    check_all();
    chk("reset_rd_data", 32'(bus.rd_data), 32'd0);
    @(negedge clk); reset = 1'b1;

    basic_capture();

    // Wrap with PC-match trigger, drained under backpressure
    arm = 1'b1; cycle();
    trig_pc_en = 1'b1; trig_pc = 4'hC; post_count = 3'd2;
    for (int p = 0; p < 16; p++) push(4'(p));
    chk("wrap_wrapped", 32'(wrapped), 32'd1);
    chk("wrap_fill", 32'(fill), 32'd8);
    chk("wrap_first", 32'(bus.rd_data[15:12]), 32'd7);
    trig_pc_en = 1'b0;
    drain(3);

    // Reset during POST with one entry remaining
    arm = 1'b1; cycle();
    post_count = 3'd2; force_trig = 1'b1; push(4'h0);
    push(4'h1);
    chk("post_state", 32'(state), 32'd2);
    #3 reset = 1'b0;
    #1 model_reset();
    check_all();
    chk("midreset_rd_data", 32'(bus.rd_data), 32'd0);
    @(negedge clk); reset = 1'b1;
    basic_capture();

    // arm wins over trigger and write in the same cycle
    arm = 1'b1; cycle();
    trig_pc_en = 1'b1; trig_pc = 4'h5;
    push(4'h1);
    arm = 1'b1; push(4'h5);
    chk("rearm_state", 32'(state), 32'd1);
    chk("rearm_fill", 32'(fill), 32'd0);
    trig_pc_en = 1'b0;

    // Trigger with nothing captured
    arm = 1'b1; cycle();
    force_trig = 1'b1; post_count = 3'd0; cycle();
    cycle();
    chk("empty_idle", 32'(state), 32'd0);

    // Randomized sessions
    for (int it = 0; it < 40; it++) begin
      int k;
      arm = 1'b1; cycle();
      trig_pc_en = 1'($urandom_range(0, 1));
      trig_pc = 4'($urandom_range(0, 15));
      k = 0;
      while (m_state != 0 && k < 300) begin
        bus.trace_valid  = ($urandom_range(0, 3) != 0);
        bus.trace_pc     = 4'($urandom_range(0, 15));
        bus.trace_inst   = 8'($urandom_range(0, 255));
        bus.trace_result = 4'($urandom_range(0, 15));
        force_trig       = ($urandom_range(0, 15) == 0);
        post_count       = 3'($urandom_range(0, 7));
        bus.rd_ready     = ($urandom_range(0, 2) != 0);
        arm              = ($urandom_range(0, 99) == 0);
        cycle();
        k++;
      end
      chk("rand_timeout", 32'(m_state == 0), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
Parametrised on-chip execution trace capture for the CPU core. It records per-instruction {pc, instruction, alu_result} into a circular buffer while armed, stops a programmable number of entries after a PC-match or forced trigger, then streams the captured window oldest-first over a valid/ready port. It sits beside cpu_top, fed from its pc/instruction/alu_result nets, and replaces print-based execution monitoring with a synthesizable, self-checkable trace.

Parameters:
PC_W, 4, program counter width
INST_W, 8, instruction width
DATA_W, 4, ALU result width
DEPTH, 8, buffer entries; power of two, >= 2
PTR_W, $clog2(DEPTH), pointer width (derived, do not override)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
trace_valid  in  1  one instruction retired this cycle
trace_pc  in  PC_W  PC of retired instruction
trace_inst  in  INST_W  retired instruction word
trace_result  in  DATA_W  ALU result of retired instruction
arm  in  1  pulse: clear buffer, start capture
trig_pc_en  in  1  enable PC-match trigger
trig_pc  in  PC_W  PC-match trigger value
force_trig  in  1  pulse: trigger immediately
post_count  in  PTR_W  entries to capture after the trigger entry; sampled at trigger
rd_valid  out  1  rd_data holds a captured entry
rd_ready  in  1  consumer accepts rd_data
rd_data  out  PC_W+INST_W+DATA_W  {pc, inst, result}, pc in MSBs
rd_last  out  1  rd_data is the newest captured entry
state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
fill  out  PTR_W+1  valid entries held, saturates at DEPTH
wrapped  out  1  buffer overwrote at least one entry since arm

Behaviour:
- Reset (reset=0, async): state=IDLE, wr_ptr=0, rd_ptr=0, fill=0, wrapped=0, remaining=0, rd_valid=0, rd_last=0, rd_data=0. Buffer contents are don't-care.
- Writes: on trace_valid in ARMED or POST, entry is written at wr_ptr; wr_ptr = (wr_ptr+1) mod DEPTH; fill increments, saturating at DEPTH; once a write lands with fill==DEPTH, wrapped=1. trace_valid is ignored in IDLE and DONE.
- IDLE: arm -> ARMED, clearing wr_ptr, fill and wrapped.
- ARMED: trigger = force_trig | (trace_valid & trig_pc_en & trace_pc==trig_pc).
  - The triggering entry is written that same cycle when trace_valid=1. force_trig with trace_valid=0 writes nothing.
  - On trigger: if post_count==0 -> DONE; else remaining=post_count -> POST.
- POST: each trace_valid writes and decrements remaining. The write that brings remaining to 0 -> DONE. force_trig and trig match are ignored.
- DONE (cycle after entry):
  - rd_ptr = wrapped ? wr_ptr : 0.
  - rd_valid=1 if fill>0. rd_data is registered from buffer[rd_ptr].
  - Each rd_valid&rd_ready advances rd_ptr mod DEPTH and decrements an internal read count.
  - rd_last=1 on the final entry; accepting it -> IDLE with rd_valid=0. Entries are delivered in write order, oldest first.
  - fill==0 in DONE -> IDLE next cycle, with no rd_valid.
- rd_data/rd_valid are held stable while rd_valid=1 and rd_ready=0.
- arm while ARMED, POST or DONE: restart. State goes to ARMED, pointers/fill/wrapped are cleared, rd_valid drops, and any in-progress readout is discarded. arm has priority over trigger and over a write in the same cycle; that cycle's trace entry is dropped.
- Capacity: window = up to DEPTH entries ending at the final post-trigger entry. Pre-trigger history is truncated by wrap.
- Latency: trigger-to-DONE = 1 cycle when post_count=0. DONE-to-first rd_valid = 1 cycle.

Test Plan:
- Basic capture: reset, arm, 5 entries pc=0..4 (inst=8'h10+pc, result=pc), force_trig with post_count=0 after pc=4 -> DONE, fill=5, wrapped=0, stream pc 0,1,2,3,4 with rd_last on pc=4, then IDLE.
- Wrap + PC trigger: DEPTH=8, trig_pc_en=1, trig_pc=4'hC, post_count=2, feed pc=0..15 -> stops after pc=14, wrapped=1, fill=8, reads pc 7..14 in order.
- Backpressure: during readout hold rd_ready=0 for 3 cycles on each entry -> rd_data stable while stalled, no entry skipped or duplicated, rd_last once.
- Reset mid-operation: assert reset low in POST with remaining=1 -> outputs immediately at reset values, state=IDLE; after release a fresh arm/capture behaves as the basic-capture case.
- Re-arm priority: in ARMED, same cycle arm=1, trace_valid=1, trace_pc=trig_pc -> stays ARMED, fill=0, entry not written.
- Empty trigger: arm then force_trig with no trace_valid, post_count=0 -> DONE then IDLE, rd_valid never asserted.
